sblk_ctrl: RTL and testbench

SBLK_CTRL -- requirements
Module: sblk_ctrl

---
 rtl/sblk_pkg.sv | 23 ++
 rtl/sblk_delay_line.sv | 34 +++
 rtl/sblk_ctrl.sv | 161 ++++++++++++++++
 tb/tb_sblk_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sblk_pkg.sv
// Shared types and default geometry for the superblock controller and its superblock unit.
package sblk_pkg;

  localparam int DEF_N_TILE       = 40;
  localparam int DEF_WID_ACT      = 16;
  localparam int DEF_WID_ACTADDR  = 6;
  localparam int DEF_WID_WADDR    = 10;
  localparam int DEF_WID_PSUMADDR = 9;
  localparam int DEF_PSUM_LAT     = 48;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_DONE    = 3'd4
  } sblk_state_e;

  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/sblk_delay_line.sv
// Fixed-latency register pipeline; dout(t + DEPTH) = din(t).
module sblk_delay_line
  import sblk_pkg::*;
#(
  parameter int WIDTH = DEF_WID_PSUMADDR + 1,
  parameter int DEPTH = DEF_PSUM_LAT
) (
  input  logic             clk_l,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] q_reg;
      if (gi == 0) begin : g_head
        always_ff @(posedge clk_l or negedge rst_n) begin
          if (!rst_n) q_reg <= '0;
          else        q_reg <= din;
        end
      end else begin : g_tail
        always_ff @(posedge clk_l or negedge rst_n) begin
          if (!rst_n) q_reg <= '0;
          else        q_reg <= g_stage[gi-1].q_reg;
        end
      end
    end
  endgenerate

  assign dout = g_stage[DEPTH-1].q_reg;

endmodule

// File: rtl/sblk_ctrl.sv
// Superblock controller: streams activations into the tiles, sequences compute
// steps, and waits for the psum pipeline to drain before signalling completion.
module sblk_ctrl
  import sblk_pkg::*;
#(
  parameter int N_TILE       = DEF_N_TILE,
  parameter int WID_ACT      = DEF_WID_ACT,
  parameter int WID_ACTADDR  = DEF_WID_ACTADDR,
  parameter int WID_WADDR    = DEF_WID_WADDR,
  parameter int WID_PSUMADDR = DEF_WID_PSUMADDR,
  parameter int PSUM_LAT     = DEF_PSUM_LAT
) (
  input  logic                    clk_l,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [WID_ACTADDR-1:0]  cfg_act_rows,
  input  logic [WID_WADDR:0]      cfg_len,
  input  logic                    act_in_valid,
  output logic                    act_in_ready,
  input  logic [2*WID_ACT-1:0]    act_in_data,
  output logic [2*WID_ACT-1:0]    act_data_in,
  output logic [N_TILE-1:0]       act_wr_en,
  output logic [WID_ACTADDR-2:0]  act_wr_addr_hbit,
  output logic [WID_ACTADDR-2:0]  act_rd_addr_hbit,
  output logic [WID_WADDR-1:0]    w_rd_addr,
  output logic [WID_PSUMADDR-1:0] psum_rd_addr,
  output logic [WID_PSUMADDR-1:0] psum_wr_addr,
  output logic                    psum_wr_en,
  output logic                    busy,
  output logic                    done
);

  localparam int TILE_W = clog2_min1(N_TILE);
  localparam int INF_W  = 7;
  localparam logic [TILE_W-1:0]      TILE_LAST = TILE_W'(N_TILE - 1);
  localparam logic [TILE_W-1:0]      TILE_INC  = TILE_W'(1);
  localparam logic [N_TILE-1:0]      TILE_BIT0 = N_TILE'(1);
  localparam logic [WID_ACTADDR-1:0] ROW_INC   = WID_ACTADDR'(1);
  localparam logic [WID_WADDR:0]     STEP_INC  = (WID_WADDR + 1)'(1);

  sblk_state_e state_reg, state_next;

  logic [WID_ACTADDR-1:0]  cfg_rows_reg;
  logic [WID_WADDR:0]      cfg_len_reg;
  logic [TILE_W-1:0]       tile_reg;
  logic [WID_ACTADDR-1:0]  row_reg, row_next;
  logic [WID_WADDR:0]      step_reg, step_next;
  logic                    step_valid_reg;
  logic [INF_W-1:0]        inflight_reg, inflight_next;
  logic [2*WID_ACT-1:0]    act_data_reg;
  logic [N_TILE-1:0]       act_wr_en_reg;
  logic [WID_ACTADDR-2:0]  act_wr_hbit_reg, act_rd_hbit_reg;
  logic [WID_WADDR-1:0]    w_rd_addr_reg;
  logic [WID_PSUMADDR-1:0] psum_rd_addr_reg;
  logic [WID_PSUMADDR:0]   dl_out;
  logic                    act_hs, load_last, comp_last, drain_empty;

  assign act_hs        = act_in_valid && (state_reg == ST_LOAD);
  assign row_next      = row_reg + ROW_INC;
  assign step_next     = step_reg + STEP_INC;
  assign load_last     = (tile_reg == TILE_LAST) && (row_next == cfg_rows_reg);
  assign comp_last     = (step_next == cfg_len_reg);
  // Counts steps issued but not yet written back, so DRAIN ends exactly when the pipe empties.
  assign inflight_next = inflight_reg + INF_W'(step_valid_reg) - INF_W'(psum_wr_en);
  assign drain_empty   = (inflight_next == '0);

  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      ST_IDLE: begin
        if (start) begin
          if (cfg_act_rows != '0) state_next = ST_LOAD;
          else if (cfg_len != '0) state_next = ST_COMPUTE;
          else                    state_next = ST_DRAIN;
        end
      end
      ST_LOAD:    if (act_hs && load_last) state_next = (cfg_len_reg != '0) ? ST_COMPUTE : ST_DRAIN;
      ST_COMPUTE: if (comp_last) state_next = ST_DRAIN;
      ST_DRAIN:   if (drain_empty) state_next = ST_DONE;
      ST_DONE:    state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    act_in_ready = (state_reg == ST_LOAD);
    busy         = (state_reg != ST_IDLE);
    done         = (state_reg == ST_DONE);
  end

  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      cfg_rows_reg     <= '0;
      cfg_len_reg      <= '0;
      tile_reg         <= '0;
      row_reg          <= '0;
      step_reg         <= '0;
      step_valid_reg   <= 1'b0;
      inflight_reg     <= '0;
      act_data_reg     <= '0;
      act_wr_en_reg    <= '0;
      act_wr_hbit_reg  <= '0;
      act_rd_hbit_reg  <= '0;
      w_rd_addr_reg    <= '0;
      psum_rd_addr_reg <= '0;
    end else begin
      act_wr_en_reg  <= '0;
      step_valid_reg <= 1'b0;
      inflight_reg   <= inflight_next;
      if (state_reg == ST_IDLE && start) begin
        cfg_rows_reg <= cfg_act_rows;
        cfg_len_reg  <= cfg_len;
        tile_reg     <= '0;
        row_reg      <= '0;
        step_reg     <= '0;
      end
      if (act_hs) begin
        act_data_reg    <= act_in_data;
        act_wr_en_reg   <= TILE_BIT0 << tile_reg;
        act_wr_hbit_reg <= row_reg[WID_ACTADDR-2:0];
        if (tile_reg == TILE_LAST) begin
          tile_reg <= '0;
          row_reg  <= row_next;
        end else begin
          tile_reg <= tile_reg + TILE_INC;
        end
      end
      if (state_reg == ST_COMPUTE) begin
        w_rd_addr_reg    <= step_reg[WID_WADDR-1:0];
        act_rd_hbit_reg  <= step_reg[WID_ACTADDR-2:0];
        psum_rd_addr_reg <= step_reg[WID_PSUMADDR-1:0];
        step_valid_reg   <= 1'b1;
        step_reg         <= step_next;
      end
    end
  end

  sblk_delay_line #(
    .WIDTH (WID_PSUMADDR + 1),
    .DEPTH (PSUM_LAT)
  ) u_psum_dly (
    .clk_l (clk_l),
    .rst_n (rst_n),
    .din   ({step_valid_reg, psum_rd_addr_reg}),
    .dout  (dl_out)
  );

  assign {psum_wr_en, psum_wr_addr} = dl_out;
  assign act_data_in      = act_data_reg;
  assign act_wr_en        = act_wr_en_reg;
  assign act_wr_addr_hbit = act_wr_hbit_reg;
  assign act_rd_addr_hbit = act_rd_hbit_reg;
  assign w_rd_addr        = w_rd_addr_reg;
  assign psum_rd_addr     = psum_rd_addr_reg;

endmodule

// File: tb/tb_sblk_ctrl.sv
// Self-checking bench for sblk_ctrl with 4 tiles and a 3-cycle psum latency.
module tb_sblk_ctrl;

  localparam int PSUM_LAT = 3;

  logic        clk_l = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  cfg_act_rows = '0;
  logic [10:0] cfg_len = '0;
  logic        act_in_valid = 1'b0;
  logic        act_in_ready;
  logic [31:0] act_in_data = '0;
  logic [31:0] act_data_in;
  logic [3:0]  act_wr_en;
  logic [4:0]  act_wr_addr_hbit, act_rd_addr_hbit;
  logic [9:0]  w_rd_addr;
  logic [8:0]  psum_rd_addr, psum_wr_addr;
  logic        psum_wr_en, busy, done;

  sblk_ctrl #(
    .N_TILE(4), .WID_ACT(16), .WID_ACTADDR(6), .WID_WADDR(10),
    .WID_PSUMADDR(9), .PSUM_LAT(PSUM_LAT)
  ) dut (
    .clk_l(clk_l), .rst_n(rst_n), .start(start),
    .cfg_act_rows(cfg_act_rows), .cfg_len(cfg_len),
    .act_in_valid(act_in_valid), .act_in_ready(act_in_ready), .act_in_data(act_in_data),
    .act_data_in(act_data_in), .act_wr_en(act_wr_en),
    .act_wr_addr_hbit(act_wr_addr_hbit), .act_rd_addr_hbit(act_rd_addr_hbit),
    .w_rd_addr(w_rd_addr), .psum_rd_addr(psum_rd_addr), .psum_wr_addr(psum_wr_addr),
    .psum_wr_en(psum_wr_en), .busy(busy), .done(done)
  );

  always #5 clk_l = ~clk_l;

  typedef struct { logic [31:0] data; logic [3:0] en; logic [4:0] hbit; } beat_vec_t;
  typedef struct { int cyc; logic [9:0] w; logic [4:0] h; logic [8:0] p; } rd_exp_t;
  typedef struct { int cyc; logic [8:0] a; } psum_exp_t;

  beat_vec_t vec [8];
  beat_vec_t act_q [$];
  rd_exp_t   rd_q [$];
  psum_exp_t psum_q [$];
  beat_vec_t mon_bv;
  rd_exp_t   mon_rd;
  psum_exp_t mon_ps;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  logic beat_now = 1'b0;
  logic prev_beat = 1'b0;
  logic [127:0] all_out;

  assign all_out = {50'b0, act_in_ready, act_data_in, act_wr_en, act_wr_addr_hbit,
                    act_rd_addr_hbit, w_rd_addr, psum_rd_addr, psum_wr_addr,
                    psum_wr_en, busy, done};

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  always @(posedge clk_l) begin
    cyc       <= cyc + 1;
    prev_beat <= beat_now;
  end

  // Scoreboard monitor: pops expectations as the DUT produces writes and reads.
  always @(negedge clk_l) begin
    if (rst_n) begin
      if (prev_beat && act_q.size() > 0) begin
        mon_bv = act_q.pop_front();
        chk("act_wr_en", act_wr_en, mon_bv.en);
        chk("act_wr_addr_hbit", act_wr_addr_hbit, mon_bv.hbit);
        chk("act_data_in", act_data_in, mon_bv.data);
      end else begin
        chk("act_wr_en_no_beat", act_wr_en, 4'b0);
      end
      if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
        mon_rd = rd_q.pop_front();
        chk("w_rd_addr", w_rd_addr, mon_rd.w);
        chk("act_rd_addr_hbit", act_rd_addr_hbit, mon_rd.h);
        chk("psum_rd_addr", psum_rd_addr, mon_rd.p);
      end
      if (psum_q.size() > 0 && psum_q[0].cyc == cyc) begin
        mon_ps = psum_q.pop_front();
        chk("psum_wr_en", psum_wr_en, 1'b1);
        chk("psum_wr_addr", psum_wr_addr, mon_ps.a);
      end else if (psum_wr_en) begin
        chk("psum_wr_en_spurious", psum_wr_en, 1'b0);
      end
    end
  end

  task automatic do_start(input logic [5:0] rows, input logic [10:0] len);
    @(posedge clk_l); #1;
    start = 1'b1; cfg_act_rows = rows; cfg_len = len;
    @(posedge clk_l); #1;
    start = 1'b0;
    cfg_act_rows = 6'($urandom_range(1, 32));
    cfg_len = 11'($urandom_range(1, 1024));
  endtask

  task automatic push_compute(input int base, input int len);
    for (int i = 0; i < len; i++) begin
      rd_q.push_back('{base + 1 + i, 10'(i), 5'(i), 9'(i)});
      psum_q.push_back('{base + 1 + PSUM_LAT + i, 9'(i)});
    end
  endtask

  task automatic run_load(input int n_beats, input bit toggle, input int start_at);
    for (int i = 0; i < n_beats; i++) begin
      if (toggle && i > 0) begin
        act_in_valid = 1'b0; beat_now = 1'b0; act_in_data = $urandom;
        @(posedge clk_l); #1;
      end
      start = (i == start_at);
      if (i == start_at) begin cfg_act_rows = 6'd5; cfg_len = 11'd9; end
      act_in_valid = 1'b1; beat_now = 1'b1; act_in_data = vec[i].data;
      act_q.push_back(vec[i]);
      @(posedge clk_l); #1;
    end
    start = 1'b0; act_in_valid = 1'b0; beat_now = 1'b0;
  endtask

  task automatic wait_done(input string job, input bit start_in_done);
    int n = 0;
    int seen = 0;
    int extra = 0;
    while (seen == 0 && n < 4000) begin
      @(negedge clk_l);
      n++;
      if (done) seen = 1;
    end
    chk({job, "_done_seen"}, seen, 1);
    if (start_in_done) begin
      start = 1'b1; cfg_act_rows = 6'd0; cfg_len = 11'd5;
    end
    @(posedge clk_l); #1;
    start = 1'b0;
    repeat (6) begin
      @(negedge clk_l);
      if (done) extra++;
    end
    chk({job, "_done_extra"}, extra, 0);
    chk({job, "_busy_after"}, busy, 1'b0);
    chk({job, "_act_q_left"}, act_q.size(), 0);
    chk({job, "_rd_q_left"}, rd_q.size(), 0);
    chk({job, "_psum_q_left"}, psum_q.size(), 0);
    $display("job %s complete after %0d cycles", job, n);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0] = '{32'h1, 4'b0001, 5'd0};
    vec[1] = '{32'h2, 4'b0010, 5'd0};
    vec[2] = '{32'h3, 4'b0100, 5'd0};
    vec[3] = '{32'h4, 4'b1000, 5'd0};
    vec[4] = '{32'h5, 4'b0001, 5'd1};
    vec[5] = '{32'h6, 4'b0010, 5'd1};
    vec[6] = '{32'h7, 4'b0100, 5'd1};
    vec[7] = '{32'h8, 4'b1000, 5'd1};

    #3;
    chk("reset_outputs", all_out, '0);
    #20;
    @(negedge clk_l);
    rst_n = 1'b1;
    @(negedge clk_l);
    chk("idle_outputs", all_out, '0);

    // Job 1: two rows over four tiles, back-to-back beats, no compute.
    do_start(6'd2, 11'd0);
    chk("j1_ready", act_in_ready, 1'b1);
    chk("j1_busy", busy, 1'b1);
    run_load(8, 1'b0, -1);
    wait_done("j1_load_b2b", 1'b0);

    // Job 2: same job, valid toggling every other cycle.
    do_start(6'd2, 11'd0);
    run_load(8, 1'b1, -1);
    wait_done("j2_load_gaps", 1'b0);

    // Job 3: compute only, short.
    do_start(6'd0, 11'd5);
    chk("j3_ready", act_in_ready, 1'b0);
    push_compute(cyc, 5);
    wait_done("j3_compute5", 1'b0);

    // Job 4: full-length compute exercising all address wraps.
    do_start(6'd0, 11'd1024);
    push_compute(cyc, 1024);
    wait_done("j4_compute1024", 1'b0);

    // Job 5: start pulsed during LOAD and during DONE must be ignored.
    do_start(6'd1, 11'd3);
    run_load(4, 1'b0, 2);
    push_compute(cyc, 3);
    wait_done("j5_start_ignored", 1'b1);

    // Job 6: asynchronous reset in the middle of COMPUTE.
    do_start(6'd0, 11'd10);
    rd_q.push_back('{cyc + 1, 10'd0, 5'd0, 9'd0});
    @(posedge clk_l); @(posedge clk_l); #1;
    chk("j6_busy_before_rst", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("j6_rst_async_outputs", all_out, '0);
    @(negedge clk_l); @(negedge clk_l);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_l);
      chk("j6_post_rst_outputs", all_out, '0);
    end
    chk("j6_rd_q_left", rd_q.size(), 0);
    $display("job j6_reset_mid_compute complete");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
